// File: rtl/io_controller.sv
// rtl/io_controller.sv - memory-mapped switch, debounced button and 7-segment display peripheral
module io_controller #(
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00,
  parameter int          NDIGITS         = 8,
  parameter int          NSW             = 16,
  parameter int          NBTN            = 2,
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          REFRESH_CYCLES  = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memwrite,
  input  logic [31:0]        adr,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               sel,
  input  logic [NSW-1:0]     SW,
  input  logic [NBTN-1:0]    BTN,
  output logic [NDIGITS-1:0] AN,
  output logic [6:0]         A2G,
  output logic               DP
);

  localparam int DW = 4 * NDIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [NSW-1:0]     sw_s1, sw_s2;
  logic [NBTN-1:0]    btn_s1, btn_s2;
  logic [NBTN-1:0]    level, flags, accept, rise, clr;
  logic [CW-1:0]      dcnt [NBTN];
  logic [DW-1:0]      display;
  logic [NDIGITS-1:0] en_mask, dp_mask;
  logic [RW-1:0]      rcnt;
  logic [IW-1:0]      idx;
  logic               wr, wr_status, wr_display, wr_ctrl;
  logic [31:0]        rd;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign sel        = (adr[31:8] == IO_BASE[31:8]);
  assign wr         = memwrite && sel && (adr[1:0] == 2'b00);
  assign wr_status  = wr && (adr[7:0] == 8'h00);
  assign wr_display = wr && (adr[7:0] == 8'h08);
  assign wr_ctrl    = wr && (adr[7:0] == 8'h0C);
  assign clr        = wr_status ? writedata[NBTN-1:0] : '0;

  // Two-flop synchronisers for the asynchronous switch and button inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      btn_s1 <= BTN;
      btn_s2 <= btn_s1;
    end
  end

  // A button level is accepted on the cycle its counter would reach DEBOUNCE_CYCLES
  always_comb begin
    accept = '0;
    for (int i = 0; i < NBTN; i++) begin
      accept[i] = (btn_s2[i] != level[i]) && (dcnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
    rise = accept & btn_s2;
  end

  // Debounce counters, accepted levels and sticky event flags (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
      flags <= '0;
      for (int i = 0; i < NBTN; i++) dcnt[i] <= '0;
    end else begin
      level <= (level & ~accept) | (btn_s2 & accept);
      flags <= (flags & ~clr) | rise;
      for (int i = 0; i < NBTN; i++) begin
        if (btn_s2[i] == level[i] || accept[i]) dcnt[i] <= '0;
        else                                    dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end

  // Display digit values and enable / decimal-point masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display <= '0;
      en_mask <= '1;
      dp_mask <= '0;
    end else begin
      if (wr_display) display <= writedata[DW-1:0];
      if (wr_ctrl) begin
        en_mask <= writedata[NDIGITS-1:0];
        dp_mask <= writedata[8+NDIGITS-1:8];
      end
    end
  end

  // Refresh counter; each wrap advances the active digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_CYCLES - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // Drive the active digit, or blank everything when that digit is disabled
  always_comb begin
    AN  = '1;
    A2G = 7'b1111111;
    DP  = 1'b1;
    if (en_mask[idx]) begin
      AN[idx] = 1'b0;
      A2G     = hex7(display[idx*4 +: 4]);
      DP      = ~dp_mask[idx];
    end
  end

  // Zero-wait-state read mux; unmapped offsets and foreign addresses read 0
  always_comb begin
    rd = '0;
    if (sel) begin
      case (adr[7:0])
        8'h00: begin
          rd[NBTN-1:0]       = flags;
          rd[16+NBTN-1:16]   = level;
        end
        8'h04: rd[NSW-1:0]   = sw_s2;
        8'h08: rd[DW-1:0]    = display;
        8'h0C: begin
          rd[NDIGITS-1:0]    = en_mask;
          rd[8+NDIGITS-1:8]  = dp_mask;
        end
        default: rd = '0;
      endcase
    end
  end

  assign readdata = rd;

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - scoreboard bench for io_controller
module tb_io_controller;

  logic        clk = 1'b0;
  logic        reset, memwrite, sel, DP;
  logic [31:0] adr, writedata, readdata;
  logic [15:0] SW;
  logic [1:0]  BTN;
  logic [3:0]  AN;
  logic [6:0]  A2G;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  io_controller #(
    .IO_BASE(32'hFFFF_FF00), .NDIGITS(4), .NSW(16), .NBTN(2),
    .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .readdata(readdata), .sel(sel),
    .SW(SW), .BTN(BTN), .AN(AN), .A2G(A2G), .DP(DP)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sbq.size() == 0) begin
      check_eq("sb_underflow", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] seg(input logic [3:0] an, input logic [6:0] g, input logic dp);
    return {20'd0, an, g, dp};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    adr = a;
    writedata = d;
    memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    sb_push(tag, exp);
    #1;
    sb_pop(readdata);
  endtask

  // Advance to the first cycle of the digit-0 slot, bounded by a cycle budget
  task automatic sync_digit0(input string tag);
    int n = 0;
    while (AN == 4'b1110 && n < 50) begin tick(); n++; end
    while (AN != 4'b1110 && n < 50) begin tick(); n++; end
    check_eq(tag, 32'(n >= 50), 32'd0);
  endtask

  task automatic scan_frame(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] tab [4];
    tab[0] = d0; tab[1] = d1; tab[2] = d2; tab[3] = d3;
    for (int j = 0; j < 9; j++) sb_push($sformatf("%s_c%0d", tag, j), tab[(j / 2) % 4]);
    for (int j = 0; j < 9; j++) begin
      sb_pop(seg(AN, A2G, DP));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    memwrite = 1'b0;
    adr = 32'hFFFF_FF08;
    writedata = '0;
    SW = '0;
    BTN = '0;
    tick();
    tick();

    sb_push("reset_seg", seg(4'b1110, 7'b0000001, 1'b1));
    sb_pop(seg(AN, A2G, DP));
    bus_read("reset_display", 32'hFFFF_FF08, 32'h0);
    bus_read("reset_ctrl", 32'hFFFF_FF0C, 32'h0000_000F);
    bus_read("reset_status", 32'hFFFF_FF00, 32'h0);
    tick();
    reset = 1'b0;

    bus_write(32'hFFFF_FF08, 32'h0000_1234);
    bus_write(32'hFFFF_FF0C, 32'h0000_010F);
    bus_read("display_rb", 32'hFFFF_FF08, 32'h0000_1234);
    bus_read("ctrl_rb", 32'hFFFF_FF0C, 32'h0000_010F);
    sync_digit0("scan_sync");
    scan_frame("scan",
               seg(4'b1110, 7'b1001100, 1'b0),
               seg(4'b1101, 7'b0000110, 1'b1),
               seg(4'b1011, 7'b0010010, 1'b1),
               seg(4'b0111, 7'b1001111, 1'b1));

    bus_write(32'hFFFF_FF0C, 32'h0000_0005);
    sync_digit0("blank_sync");
    scan_frame("blank",
               seg(4'b1110, 7'b1001100, 1'b1),
               seg(4'b1111, 7'b1111111, 1'b1),
               seg(4'b1011, 7'b0010010, 1'b1),
               seg(4'b1111, 7'b1111111, 1'b1));

    SW = 16'h1234;
    adr = 32'hFFFF_FF04;
    sb_push("sw_1clk", 32'h0);
    tick();
    sb_pop(readdata);
    sb_push("sw_2clk", 32'h0000_1234);
    tick();
    sb_pop(readdata);

    adr = 32'hFFFF_FF00;
    BTN = 2'b10;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) BTN = 2'b00;
      sb_push($sformatf("glitch_%0d", i), 32'h0);
      tick();
      sb_pop(readdata);
    end

    BTN = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      sb_push($sformatf("hold_%0d", i), (i == 6) ? 32'h0002_0002 : 32'h0);
      tick();
      sb_pop(readdata);
    end

    bus_write(32'hFFFF_FF00, 32'h0000_0002);
    bus_read("w1c", 32'hFFFF_FF00, 32'h0002_0000);

    BTN = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      sb_push($sformatf("btn0_wait_%0d", i), 32'h0002_0000);
      tick();
      sb_pop(readdata);
    end
    writedata = 32'h0000_0001;
    memwrite = 1'b1;
    sb_push("set_beats_clr", 32'h0003_0001);
    tick();
    memwrite = 1'b0;
    sb_pop(readdata);
    bus_write(32'hFFFF_FF00, 32'h0000_0001);
    bus_read("w1c_bit0", 32'hFFFF_FF00, 32'h0003_0000);

    bus_write(32'hFFFF_FF09, 32'hFFFF_FFFF);
    bus_write(32'hFFFF_FF10, 32'hFFFF_FFFF);
    bus_read("misaligned_wr", 32'hFFFF_FF08, 32'h0000_1234);
    bus_read("unmapped_rd", 32'hFFFF_FF10, 32'h0);
    bus_read("foreign_rd", 32'h0000_0008, 32'h0);
    sb_push("foreign_sel", 32'h0);
    sb_pop(32'(sel));
    tick();

    reset = 1'b1;
    #1;
    bus_read("midrst_status", 32'hFFFF_FF00, 32'h0);
    bus_read("midrst_display", 32'hFFFF_FF08, 32'h0);
    sb_push("midrst_seg", seg(4'b1110, 7'b0000001, 1'b1));
    sb_pop(seg(AN, A2G, DP));
    tick();
    bus_read("midrst_ctrl", 32'hFFFF_FF0C, 32'h0000_000F);
    reset = 1'b0;
    tick();

    check_eq("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
